// File: rtl/ccm_pkg.sv
// Shared definitions for the colour correction matrix: coefficient
// indices, width helpers and the reset (identity) coefficient values.
package ccm_pkg;

    // Coefficient indices, row-major: output colour first, input colour second
    localparam logic [3:0] CCM_RR = 4'd0;
    localparam logic [3:0] CCM_RG = 4'd1;
    localparam logic [3:0] CCM_RB = 4'd2;
    localparam logic [3:0] CCM_GR = 4'd3;
    localparam logic [3:0] CCM_GG = 4'd4;
    localparam logic [3:0] CCM_GB = 4'd5;
    localparam logic [3:0] CCM_BR = 4'd6;
    localparam logic [3:0] CCM_BG = 4'd7;
    localparam logic [3:0] CCM_BB = 4'd8;

    localparam int CCM_NUM_COEF = 9;

    // Total coefficient width: signed integer part plus fraction
    function automatic int ccmCoefWidth(input int intWidth, input int fractWidth);
        return intWidth + fractWidth;
    endfunction

    // Three packed components, rounded up to whole bytes
    function automatic int ccmDataWidth(input int pxWidth);
        return ((3 * pxWidth + 7) / 8) * 8;
    endfunction

    // Identity matrix entry: 1.0 on the diagonal, 0 elsewhere
    function automatic logic [31:0] ccmIdentity(input int idx, input int fractWidth);
        if ((idx == int'(CCM_RR)) || (idx == int'(CCM_GG)) || (idx == int'(CCM_BB))) begin
            return 32'd1 << fractWidth;
        end
        return 32'd0;
    endfunction

endpackage

// File: rtl/ccm_dot3.sv
// One matrix row: three signed products, a rounded sum and a clamp back
// to the pixel range, spread across three pipeline stages. The enables
// come from the handshake logic in the top level.
module ccm_dot3 #(
    parameter int PX_WIDTH    = 10,
    parameter int FRACT_WIDTH = 10,
    parameter int COEF_WIDTH  = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_en1,
    input  logic                  i_en2,
    input  logic                  i_en3,
    input  logic [PX_WIDTH-1:0]   i_px0,
    input  logic [PX_WIDTH-1:0]   i_px1,
    input  logic [PX_WIDTH-1:0]   i_px2,
    input  logic [COEF_WIDTH-1:0] i_coef0,
    input  logic [COEF_WIDTH-1:0] i_coef1,
    input  logic [COEF_WIDTH-1:0] i_coef2,
    output logic [PX_WIDTH-1:0]   o_px
);

    localparam int PROD_W  = PX_WIDTH + 1 + COEF_WIDTH;
    localparam int SUM_W   = PROD_W + 2;
    localparam int SHIFT_W = SUM_W - FRACT_WIDTH;
    localparam logic signed [SUM_W-1:0] ROUND_CONST = SUM_W'(1) << (FRACT_WIDTH - 1);

    logic [PX_WIDTH-1:0]        w_px   [3];
    logic [COEF_WIDTH-1:0]      w_coef [3];
    logic signed [PROD_W-1:0]   w_prod [3];
    logic signed [PROD_W-1:0]   r_prod [3];
    logic signed [SUM_W-1:0]    w_sum;
    logic signed [SUM_W-1:0]    r_sum;
    logic signed [SHIFT_W-1:0]  w_shift;
    logic [PX_WIDTH-1:0]        w_clamp;
    logic [PX_WIDTH-1:0]        r_out;

    assign w_px[0]   = i_px0;
    assign w_px[1]   = i_px1;
    assign w_px[2]   = i_px2;
    assign w_coef[0] = i_coef0;
    assign w_coef[1] = i_coef1;
    assign w_coef[2] = i_coef2;

    // Full-precision products of the unsigned pixel (zero-extended) and signed coefficient
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_prod[k] = $signed({{(COEF_WIDTH + 1){1'b0}}, w_px[k]}) *
                        $signed({{(PX_WIDTH + 1){w_coef[k][COEF_WIDTH-1]}}, w_coef[k]});
        end
    end

    // Stage 1: register the three products
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 3; k++) r_prod[k] <= '0;
        end else if (i_en1) begin
            for (int k = 0; k < 3; k++) r_prod[k] <= w_prod[k];
        end
    end

    assign w_sum = {{2{r_prod[0][PROD_W-1]}}, r_prod[0]} +
                   {{2{r_prod[1][PROD_W-1]}}, r_prod[1]} +
                   {{2{r_prod[2][PROD_W-1]}}, r_prod[2]} + ROUND_CONST;

    // Stage 2: register the guarded sum with the half-LSB rounding offset added
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_sum <= '0;
        else if (i_en2) r_sum <= w_sum;
    end

    assign w_shift = r_sum[SUM_W-1:FRACT_WIDTH];

    // Saturate the shifted result into 0 .. 2^PX_WIDTH-1
    always_comb begin
        w_clamp = w_shift[PX_WIDTH-1:0];
        if (w_shift[SHIFT_W-1]) w_clamp = '0;
        else if (|w_shift[SHIFT_W-2:PX_WIDTH]) w_clamp = '1;
    end

    // Stage 3: register the clamped component
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_out <= '0;
        else if (i_en3) r_out <= w_clamp;
    end

    assign o_px = r_out;

endmodule

// File: rtl/color_correction_matrix.sv
// 3x3 colour correction on an AXI4-Stream RGB video path. Coefficients are
// written into a shadow bank and copied to the active bank on the first
// start-of-frame beat after a commit, so a frame never sees a mixed matrix.
module color_correction_matrix
    import ccm_pkg::*;
#(
    parameter int  PX_WIDTH       = 10,
    parameter int  FRACT_WIDTH    = 10,
    parameter int  COEF_INT_WIDTH = 4,
    parameter int  TID_WIDTH      = 4,
    parameter int  TDEST_WIDTH    = 4,
    localparam int COEF_WIDTH     = ccmCoefWidth(COEF_INT_WIDTH, FRACT_WIDTH),
    localparam int TDATA_WIDTH    = ccmDataWidth(PX_WIDTH),
    localparam int KEEP_WIDTH     = TDATA_WIDTH / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [TDATA_WIDTH-1:0] video_i_tdata,
    input  logic                   video_i_tvalid,
    output logic                   video_i_tready,
    input  logic                   video_i_tlast,
    input  logic                   video_i_tuser,
    input  logic [KEEP_WIDTH-1:0]  video_i_tkeep,
    input  logic [KEEP_WIDTH-1:0]  video_i_tstrb,
    input  logic [TID_WIDTH-1:0]   video_i_tid,
    input  logic [TDEST_WIDTH-1:0] video_i_tdest,
    output logic [TDATA_WIDTH-1:0] video_o_tdata,
    output logic                   video_o_tvalid,
    input  logic                   video_o_tready,
    output logic                   video_o_tlast,
    output logic                   video_o_tuser,
    output logic [KEEP_WIDTH-1:0]  video_o_tkeep,
    output logic [KEEP_WIDTH-1:0]  video_o_tstrb,
    output logic [TID_WIDTH-1:0]   video_o_tid,
    output logic [TDEST_WIDTH-1:0] video_o_tdest,
    input  logic                   coef_wr_i,
    input  logic [3:0]             coef_addr_i,
    input  logic [COEF_WIDTH-1:0]  coef_data_i,
    input  logic                   commit_i,
    input  logic                   bypass_i,
    output logic                   pending_o
);

    localparam int SIDE_W = 1 + TDATA_WIDTH + 2 + 2 * KEEP_WIDTH + TID_WIDTH + TDEST_WIDTH;

    logic [COEF_WIDTH-1:0]  r_shadow [CCM_NUM_COEF];
    logic [COEF_WIDTH-1:0]  r_active [CCM_NUM_COEF];
    logic [COEF_WIDTH-1:0]  w_coef   [CCM_NUM_COEF];
    logic                   r_pending;
    logic                   w_apply;
    logic                   r_v1, r_v2, r_v3;
    logic                   w_rdy1, w_rdy2, w_rdy3;
    logic [SIDE_W-1:0]      w_sideIn, r_side1, r_side2, r_side3;
    logic                   w_byp3;
    logic [TDATA_WIDTH-1:0] w_raw3;
    logic [PX_WIDTH-1:0]    w_pxR, w_pxG, w_pxB;
    logic [PX_WIDTH-1:0]    w_outR, w_outG, w_outB;

    assign w_rdy3         = video_o_tready | ~r_v3;
    assign w_rdy2         = w_rdy3 | ~r_v2;
    assign w_rdy1         = w_rdy2 | ~r_v1;
    assign video_i_tready = w_rdy1;
    assign video_o_tvalid = r_v3;

    assign w_apply   = video_i_tvalid & w_rdy1 & video_i_tuser & r_pending;
    assign pending_o = r_pending;

    // The beat that triggers an apply already uses the shadow values
    always_comb begin
        for (int i = 0; i < CCM_NUM_COEF; i++) begin
            w_coef[i] = w_apply ? r_shadow[i] : r_active[i];
        end
    end

    // Shadow bank: written by software, out-of-range addresses dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < CCM_NUM_COEF; i++) r_shadow[i] <= COEF_WIDTH'(ccmIdentity(i, FRACT_WIDTH));
        end else if (coef_wr_i && (coef_addr_i <= CCM_BB)) begin
            r_shadow[coef_addr_i] <= coef_data_i;
        end
    end

    // Active bank: takes the pre-write shadow contents on an apply
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < CCM_NUM_COEF; i++) r_active[i] <= COEF_WIDTH'(ccmIdentity(i, FRACT_WIDTH));
        end else if (w_apply) begin
            for (int i = 0; i < CCM_NUM_COEF; i++) r_active[i] <= r_shadow[i];
        end
    end

    // A commit waits here until the next accepted start-of-frame beat
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_pending <= 1'b0;
        else if (commit_i) r_pending <= 1'b1;
        else if (w_apply) r_pending <= 1'b0;
    end

    assign w_sideIn = {bypass_i, video_i_tdata, video_i_tlast, video_i_tuser,
                       video_i_tkeep, video_i_tstrb, video_i_tid, video_i_tdest};

    // Per-stage valid bits and sideband payload; bubbles collapse when a stage is empty
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_side1 <= '0;
            r_side2 <= '0;
            r_side3 <= '0;
        end else begin
            if (w_rdy1) r_v1 <= video_i_tvalid;
            if (w_rdy2) r_v2 <= r_v1;
            if (w_rdy3) r_v3 <= r_v2;
            if (w_rdy1 && video_i_tvalid) r_side1 <= w_sideIn;
            if (w_rdy2 && r_v1) r_side2 <= r_side1;
            if (w_rdy3 && r_v2) r_side3 <= r_side2;
        end
    end

    assign w_pxR = video_i_tdata[3*PX_WIDTH-1:2*PX_WIDTH];
    assign w_pxB = video_i_tdata[2*PX_WIDTH-1:PX_WIDTH];
    assign w_pxG = video_i_tdata[PX_WIDTH-1:0];

    ccm_dot3 #(.PX_WIDTH(PX_WIDTH), .FRACT_WIDTH(FRACT_WIDTH), .COEF_WIDTH(COEF_WIDTH)) u_rowR (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_en1(w_rdy1 & video_i_tvalid), .i_en2(w_rdy2 & r_v1), .i_en3(w_rdy3 & r_v2),
        .i_px0(w_pxR), .i_px1(w_pxG), .i_px2(w_pxB),
        .i_coef0(w_coef[CCM_RR]), .i_coef1(w_coef[CCM_RG]), .i_coef2(w_coef[CCM_RB]),
        .o_px(w_outR)
    );

    ccm_dot3 #(.PX_WIDTH(PX_WIDTH), .FRACT_WIDTH(FRACT_WIDTH), .COEF_WIDTH(COEF_WIDTH)) u_rowG (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_en1(w_rdy1 & video_i_tvalid), .i_en2(w_rdy2 & r_v1), .i_en3(w_rdy3 & r_v2),
        .i_px0(w_pxR), .i_px1(w_pxG), .i_px2(w_pxB),
        .i_coef0(w_coef[CCM_GR]), .i_coef1(w_coef[CCM_GG]), .i_coef2(w_coef[CCM_GB]),
        .o_px(w_outG)
    );

    ccm_dot3 #(.PX_WIDTH(PX_WIDTH), .FRACT_WIDTH(FRACT_WIDTH), .COEF_WIDTH(COEF_WIDTH)) u_rowB (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_en1(w_rdy1 & video_i_tvalid), .i_en2(w_rdy2 & r_v1), .i_en3(w_rdy3 & r_v2),
        .i_px0(w_pxR), .i_px1(w_pxG), .i_px2(w_pxB),
        .i_coef0(w_coef[CCM_BR]), .i_coef1(w_coef[CCM_BG]), .i_coef2(w_coef[CCM_BB]),
        .o_px(w_outB)
    );

    assign {w_byp3, w_raw3, video_o_tlast, video_o_tuser, video_o_tkeep,
            video_o_tstrb, video_o_tid, video_o_tdest} = r_side3;

    assign video_o_tdata = w_byp3 ? w_raw3 : TDATA_WIDTH'({w_outR, w_outB, w_outG});

endmodule
